// File: rtl/intc_pkg.sv
// Shared constants for the 8051 interrupt controller:
// source indices, vector addresses, IE layout and FSM encoding.
package intc_pkg;

  localparam int SRC_INT0 = 0;
  localparam int SRC_T0   = 1;
  localparam int SRC_INT1 = 2;
  localparam int SRC_T1   = 3;
  localparam int SRC_SER  = 4;

  localparam logic [7:0] VEC_INT0 = 8'h03;
  localparam logic [7:0] VEC_T0   = 8'h0B;
  localparam logic [7:0] VEC_INT1 = 8'h13;
  localparam logic [7:0] VEC_T1   = 8'h1B;
  localparam logic [7:0] VEC_SER  = 8'h23;

  localparam int IE_EA = 7;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } intc_state_e;

  function automatic logic [7:0] vec_addr(
    input logic [2:0] idx,
    input int         stride,
    input int         offset
  );
    return 8'(offset + stride * int'(idx));
  endfunction

endpackage

// File: rtl/intc_if.sv
// Request/acknowledge bundle between the interrupt
// controller and the control unit.
interface intc_if;
  logic       irq_req;
  logic [7:0] irq_vector;
  logic       irq_ack;
  logic       reti;

  modport master (
    output irq_req,
    output irq_vector,
    input  irq_ack,
    input  reti
  );

  modport slave (
    input  irq_req,
    input  irq_vector,
    output irq_ack,
    output reti
  );
endinterface

// File: rtl/intc_prio_enc.sv
// Two-level priority encoder: high level beats low,
// lowest index wins within a level.
module intc_prio_enc #(
  parameter int NSRC = 5
) (
  input  logic [NSRC-1:0] elig,
  input  logic [NSRC-1:0] ip,
  output logic            any,
  output logic [2:0]      idx,
  output logic            level
);

  logic [NSRC-1:0] hi;
  logic [NSRC-1:0] lo;

  always_comb begin
    hi    = elig & ip;
    lo    = elig & ~ip;
    any   = |elig;
    level = |hi;
    idx   = '0;
    // Scan downward so the lowest set index is the last write.
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (level ? hi[i] : lo[i]) idx = 3'(i);
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Five-source, two-level 8051 interrupt controller:
// edge capture, IE/IP registers, in-service tracking, req/ack FSM.
module interrupt_controller
  import intc_pkg::*;
#(
  parameter int NSRC       = 5,
  parameter int VEC_STRIDE = 8,
  parameter int VEC_OFFSET = 3
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_in,
  input  logic            ie_wr,
  input  logic [7:0]      ie_din,
  input  logic            ip_wr,
  input  logic [NSRC-1:0] ip_din,
  intc_if.master          cu,
  output logic [7:0]      ie_q,
  output logic [NSRC-1:0] ip_q,
  output logic [NSRC-1:0] pend_q
);

  localparam logic [7:0] IE_MASK =
    8'(128 + (1 << NSRC) - 1);

  intc_state_e     state_q, state_d;
  logic [NSRC-1:0] prev_q;
  logic [NSRC-1:0] pend_d;
  logic [7:0]      ie_d;
  logic [NSRC-1:0] ip_d;
  logic            inserv_lo_q, inserv_lo_d;
  logic            inserv_hi_q, inserv_hi_d;
  logic [2:0]      win_idx_q, win_idx_d;
  logic            win_lvl_q, win_lvl_d;
  logic            irq_req_q, irq_req_d;
  logic [7:0]      irq_vector_q, irq_vector_d;

  logic            ea;
  logic [NSRC-1:0] evt;
  logic [NSRC-1:0] lvl_mask;
  logic [NSRC-1:0] elig;
  logic [NSRC-1:0] clr;
  logic            set_lo;
  logic            set_hi;
  logic            enc_any;
  logic [2:0]      enc_idx;
  logic            enc_lvl;

  assign ea       = ie_q[IE_EA];
  assign evt      = irq_in & ~prev_q;
  assign lvl_mask = inserv_hi_q ? '0 :
                    inserv_lo_q ? ip_q : '1;
  assign elig     = pend_q & ie_q[NSRC-1:0]
                  & {NSRC{ea}} & lvl_mask;

  intc_prio_enc #(
    .NSRC (NSRC)
  ) u_enc (
    .elig  (elig),
    .ip    (ip_q),
    .any   (enc_any),
    .idx   (enc_idx),
    .level (enc_lvl)
  );

  always_comb begin
    state_d      = state_q;
    win_idx_d    = win_idx_q;
    win_lvl_d    = win_lvl_q;
    irq_req_d    = irq_req_q;
    irq_vector_d = irq_vector_q;
    clr          = '0;
    set_lo       = 1'b0;
    set_hi       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (enc_any) begin
          state_d      = REQ;
          win_idx_d    = enc_idx;
          win_lvl_d    = enc_lvl;
          irq_req_d    = 1'b1;
          irq_vector_d = vec_addr(enc_idx, VEC_STRIDE,
                                  VEC_OFFSET);
        end
      end
      REQ: begin
        if (cu.irq_ack) begin
          state_d   = IDLE;
          irq_req_d = 1'b0;
          clr       = {{(NSRC-1){1'b0}}, 1'b1} << win_idx_q;
          set_hi    = win_lvl_q;
          set_lo    = ~win_lvl_q;
        end else if (!ea || !ie_q[win_idx_q]) begin
          state_d   = IDLE;
          irq_req_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // A fresh edge beats the acknowledge clear.
    pend_d = (pend_q & ~clr) | evt;

    inserv_lo_d = inserv_lo_q;
    inserv_hi_d = inserv_hi_q;
    if (cu.reti) begin
      if (inserv_hi_q) inserv_hi_d = 1'b0;
      else             inserv_lo_d = 1'b0;
    end
    if (set_hi) inserv_hi_d = 1'b1;
    if (set_lo) inserv_lo_d = 1'b1;

    ie_d = ie_wr ? (ie_din & IE_MASK) : ie_q;
    ip_d = ip_wr ? ip_din : ip_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      prev_q       <= '0;
      pend_q       <= '0;
      ie_q         <= '0;
      ip_q         <= '0;
      inserv_lo_q  <= 1'b0;
      inserv_hi_q  <= 1'b0;
      win_idx_q    <= '0;
      win_lvl_q    <= 1'b0;
      irq_req_q    <= 1'b0;
      irq_vector_q <= '0;
    end else begin
      state_q      <= state_d;
      prev_q       <= irq_in;
      pend_q       <= pend_d;
      ie_q         <= ie_d;
      ip_q         <= ip_d;
      inserv_lo_q  <= inserv_lo_d;
      inserv_hi_q  <= inserv_hi_d;
      win_idx_q    <= win_idx_d;
      win_lvl_q    <= win_lvl_d;
      irq_req_q    <= irq_req_d;
      irq_vector_q <= irq_vector_d;
    end
  end

  assign cu.irq_req    = irq_req_q;
  assign cu.irq_vector = irq_vector_q;

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Five-source, two-level interrupt controller for the 8051 core, sitting between the peripheral interrupt lines and `control_unit`. It latches source events, applies the IE/IP enable and priority registers, and resolves a single winner. It then presents that winner's vector to the control unit over a request/acknowledge handshake. It also tracks in-service levels so that nesting and RETI behave as on a standard 8051.

## Interface
Parameters:
- `NSRC`, 5: number of interrupt sources. Index 0 = INT0, 1 = T0, 2 = INT1, 3 = T1, 4 = serial.
- `VEC_STRIDE`, 8: byte spacing between vectors.
- `VEC_OFFSET`, 3: address of the vector for source 0.

Ports:
- `clock`  in  1  system clock. All state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `irq_in`  in  NSRC  raw source lines. A rising edge is an event.
- `ie_wr`  in  1  write strobe for IE.
- `ie_din`  in  8  IE write data. Bit 7 = EA, bits 4:0 = per-source enables. Bits 6:5 are ignored.
- `ip_wr`  in  1  write strobe for IP.
- `ip_din`  in  NSRC  IP write data. 1 = high priority.
- `irq_ack`  in  1  control unit accepts the pending request at an instruction boundary.
- `reti`  in  1  single-cycle pulse when RETI executes.
- `irq_req`  out  1  an interrupt request is pending toward the control unit.
- `irq_vector`  out  8  vector address. Valid while `irq_req` = 1.
- `ie_q`  out  8  IE readback.
- `ip_q`  out  NSRC  IP readback.
- `pend_q`  out  NSRC  pending flags readback.

## Operation
- **Edge detect:** each bit of `irq_in` is registered as `prev`. The event condition is `irq_in & ~prev`.
- **Pending flag:** an event sets that source's pending flag. Only an `irq_ack` that selects the source clears it.
- **Eligibility:** a source is eligible when its pending flag is set, its IE bit is set, EA is set, and its level is above the current service level.
  - `inserv_hi` = 1: nothing is eligible.
  - `inserv_lo` = 1: only high-priority sources are eligible.
  - Otherwise: all sources are eligible.
- **Winner selection:** high-level eligible sources beat low-level ones. Within a level, the lowest index wins.
- **Vector:** `VEC_OFFSET + VEC_STRIDE*idx`, giving 0x03, 0x0B, 0x13, 0x1B, 0x23.
- **FSM states:** IDLE and REQ.
  - IDLE -> REQ when any source is eligible. The winner's index and level are latched on the same edge.
  - REQ holds the latched winner even if a higher-priority source becomes pending. The higher source is re-arbitrated after the acknowledge.
  - REQ -> IDLE on `irq_ack`. The winner's pending flag is cleared and the in-service bit for its level is set.
  - REQ -> IDLE without acknowledge when EA or the winner's IE bit becomes 0. The pending flag is kept.
- **Ignored acknowledge:** `irq_ack` while in IDLE has no effect.
- **RETI:** `reti` clears `inserv_hi` if it is set, otherwise `inserv_lo`. With neither set it has no effect.
- **Register writes:** IE and IP writes take effect on the next edge. Eligibility uses the register contents as of that edge.

## Timing
- **Reset values:** `irq_req` = 0, `irq_vector` = 0x00, `ie_q` = 0, `ip_q` = 0, `pend_q` = 0. Also reset to 0: `prev`, `inserv_lo`, `inserv_hi`. The FSM resets to IDLE.
- **Reset mid-operation:** reset asserted while in REQ drops `irq_req` immediately (asynchronously). All pending events are lost.
- **Latency:** `irq_in` rises in the cycle sampled at edge N. The pending flag is visible after edge N. `irq_req` = 1 and `irq_vector` are valid after edge N+1.
- **Output drive:** `irq_req` and `irq_vector` are registered. `irq_vector` is stable for the entire REQ interval.
- **Deassert after acknowledge:** `irq_req` falls on the edge that samples `irq_ack` = 1. The next request can assert one edge later at the earliest.
- **Event vs. acknowledge clear:** a new event on a source in the same cycle as the acknowledge that clears it leaves the pending flag set. The event wins.
- **`reti` and `irq_ack` together:** the clear is applied first, then the set. The in-service state after the edge reflects both.
- **Reading `pend_q`:** `pend_q` reflects the flags after the edge.

## Structure
- **Package `intc_pkg`:**
  - Source index localparams: `SRC_INT0` .. `SRC_SER`.
  - Vector constants 0x03 .. 0x23.
  - FSM state encoding: IDLE, REQ.
  - IE bit position of EA (7).
- **Sub-module `intc_prio_enc`:** combinational.
  - Inputs: the eligible mask and IP.
  - Outputs: `any`, `idx[2:0]`, `level`.
  - It is the only arbitration logic. The top level holds the registers and the FSM.

## Test plan
1. **Single source:** IE = 0x81, pulse `irq_in[0]`. Required: `irq_req` = 1 two edges later with `irq_vector` = 0x03. On `irq_ack`, `pend_q[0]` = 0, `irq_req` = 0, and `inserv_lo` = 1 (observed via blocking: a second low-priority event is not requested until `reti`).
2. **Same-cycle priority:** IE = 0x9F, IP = 0, pulse sources 1 and 3 in the same cycle. Required: vector 0x0B first. After ack plus `reti`, the next vector is 0x1B.
3. **Nesting:** IP = 0x10. Ack source 0 (low priority), then pulse source 4. Required: request with 0x23 while `inserv_lo` = 1. A subsequent source-2 event (low priority) produces no request until two `reti` pulses.
4. **Request withdrawal:** IE = 0x84, source 2 in REQ, write IE = 0x04. Required: `irq_req` = 0 next edge and `pend_q[2]` stays 1. Rewriting IE = 0x84 re-raises the request with 0x13.
5. **Event vs. acknowledge collision:** a new source-0 edge in the same cycle as the ack for source 0. Required: `pend_q[0]` remains 1 and, after `reti`, vector 0x03 is requested again.
6. **Asynchronous reset in REQ:** assert `reset` mid-cycle while in REQ. Required: `irq_req` = 0 before the next clock edge, and all readbacks are 0.
